dmem_arbiter: RTL and testbench

- Two-master arbiter sharing the single data memory port (including the memory-mapped watchdog window, addr[31:28]==4'h4) between the core load/store unit (m0) and a DMA/debug master (m1).
- Accepts at most one request per cycle and registers it into a one-entry access stage that drives the memory.
- Returns read data one cycle after the access cycle.
- Supports locked sequences for atomic read-modify-write, plus starvation protection for m1.

---
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data memory port with locked sequences and m1 watchdog blocking.
// Define DMEM_ARB_RR_EN for round-robin idle arbitration instead of fixed m0 priority with starvation forcing.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_op_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_op_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_w_en,
  output logic        mem_r_en,
  output logic [2:0]  mem_op_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_w,
  input  logic [31:0] mem_data_r
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t      state_q, state_d;
  logic        gnt0_c, gnt1_c;
  logic        prefer_m1;

  logic        stage_valid_q, stage_valid_d;
  logic        stage_we_q, stage_we_d;
  logic        stage_id_q, stage_id_d;
  logic        stage_blocked_q, stage_blocked_d;
  logic [2:0]  stage_op_q, stage_op_d;
  logic [31:0] stage_addr_q, stage_addr_d;
  logic [31:0] stage_wdata_q, stage_wdata_d;

  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err_q, err_d;
  logic [31:0] resp_data;

`ifdef DMEM_ARB_RR_EN
  logic rr_q, rr_d;

  assign prefer_m1 = rr_q;

  // Pointer moves to the loser only when both masters fought for the port in IDLE.
  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && m0_req && m1_req) begin
      rr_d = ~rr_q;
    end
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign prefer_m1 = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (m1_gnt) begin
      cnt_d = '0;
    end else if (m1_req && state_q != LOCK0 && cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          gnt1_c = prefer_m1;
          gnt0_c = ~prefer_m1;
        end else begin
          gnt0_c = m0_req;
          gnt1_c = m1_req;
        end
      end
      LOCK0:   gnt0_c = m0_req;
      LOCK1:   gnt1_c = m1_req;
      default: ;
    endcase
  end

  // Grants must read 0 while reset is held, even though they are combinational.
  assign m0_gnt = gnt0_c & ~rst;
  assign m1_gnt = gnt1_c & ~rst;

  always_comb begin
    state_d = state_q;
    if (m0_gnt) begin
      state_d = m0_lock ? LOCK0 : IDLE;
    end else if (m1_gnt) begin
      state_d = m1_lock ? LOCK1 : IDLE;
    end
  end

  always_comb begin
    stage_valid_d   = m0_gnt | m1_gnt;
    stage_we_d      = 1'b0;
    stage_id_d      = 1'b0;
    stage_blocked_d = 1'b0;
    stage_op_d      = '0;
    stage_addr_d    = '0;
    stage_wdata_d   = '0;
    if (m1_gnt) begin
      stage_we_d      = m1_we;
      stage_id_d      = 1'b1;
      stage_blocked_d = (m1_addr[31:28] == 4'h4);
      stage_op_d      = m1_op_sel;
      stage_addr_d    = m1_addr;
      stage_wdata_d   = m1_wdata;
    end else if (m0_gnt) begin
      stage_we_d      = m0_we;
      stage_op_d      = m0_op_sel;
      stage_addr_d    = m0_addr;
      stage_wdata_d   = m0_wdata;
    end
  end

  always_comb begin
    resp_data = stage_blocked_q ? 32'h0 : mem_data_r;
    rvalid0_d = stage_valid_q & ~stage_we_q & ~stage_id_q;
    rvalid1_d = stage_valid_q & ~stage_we_q & stage_id_q;
    rdata0_d  = rvalid0_d ? resp_data : 32'h0;
    rdata1_d  = rvalid1_d ? resp_data : 32'h0;
    err_d     = stage_valid_q & stage_blocked_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      stage_valid_q   <= 1'b0;
      stage_we_q      <= 1'b0;
      stage_id_q      <= 1'b0;
      stage_blocked_q <= 1'b0;
      stage_op_q      <= '0;
      stage_addr_q    <= '0;
      stage_wdata_q   <= '0;
      rvalid0_q       <= 1'b0;
      rvalid1_q       <= 1'b0;
      rdata0_q        <= '0;
      rdata1_q        <= '0;
      err_q           <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_q            <= 1'b0;
`else
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      stage_valid_q   <= stage_valid_d;
      stage_we_q      <= stage_we_d;
      stage_id_q      <= stage_id_d;
      stage_blocked_q <= stage_blocked_d;
      stage_op_q      <= stage_op_d;
      stage_addr_q    <= stage_addr_d;
      stage_wdata_q   <= stage_wdata_d;
      rvalid0_q       <= rvalid0_d;
      rvalid1_q       <= rvalid1_d;
      rdata0_q        <= rdata0_d;
      rdata1_q        <= rdata1_d;
      err_q           <= err_d;
`ifdef DMEM_ARB_RR_EN
      rr_q            <= rr_d;
`else
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign mem_w_en   = stage_valid_q & stage_we_q & ~stage_blocked_q;
  assign mem_r_en   = stage_valid_q & ~stage_we_q & ~stage_blocked_q;
  assign mem_op_sel = stage_op_q;
  assign mem_addr   = stage_addr_q;
  assign mem_data_w = stage_wdata_q;

  assign m0_rvalid  = rvalid0_q;
  assign m1_rvalid  = rvalid1_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign m1_err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [2:0]  m0_op_sel, m1_op_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_w_en, mem_r_en;
  logic [2:0]  mem_op_sel;
  logic [31:0] mem_addr, mem_data_w, mem_data_r;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  localparam logic [2:0] OP_LW = 3'b010;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_op_sel(m0_op_sel), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_op_sel(m1_op_sel), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_op_sel(mem_op_sel),
    .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_r = mem[mem_addr[9:2]];

  // Single writer for the model: preload while reset is held, then accept stores.
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'hDEADBEEF;
      mem[4] <= 32'h12345678;
      mem[8] <= 32'hA5A50001;
    end else if (mem_w_en) begin
      mem[mem_addr[9:2]] <= mem_data_w;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
    m0_req = req; m0_we = we; m0_op_sel = OP_LW; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
    m1_req = req; m1_we = we; m1_op_sel = OP_LW; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp1;
    rst = 1'b1;
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1'b1;
    #1;
    check_eq("rst_m0_gnt", m0_gnt, 0);
    check_eq("rst_mem_r_en", mem_r_en, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_m0_rvalid", m0_rvalid, 0);
    m0_req = 1'b0;
    rst = 1'b0;
    tick();

    // Basic m0 load: grant, memory access, response two cycles later.
    drive_m0(1, 0, 32'h10, 0, 0);
    #1;
    check_eq("t1_m0_gnt", m0_gnt, 1);
    check_eq("t1_m1_gnt", m1_gnt, 0);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    #1;
    check_eq("t1_mem_r_en", mem_r_en, 1);
    check_eq("t1_mem_w_en", mem_w_en, 0);
    check_eq("t1_mem_addr", mem_addr, 32'h10);
    check_eq("t1_mem_op", mem_op_sel, OP_LW);
    tick();
    #1;
    check_eq("t1_m0_rvalid", m0_rvalid, 1);
    check_eq("t1_m0_rdata", m0_rdata, 32'h12345678);
    check_eq("t1_m1_rvalid", m1_rvalid, 0);
    tick();
    #1;
    check_eq("t1_m0_rvalid_pulse", m0_rvalid, 0);

    // Continuous contention: starvation forcing or round-robin alternation.
    drive_m0(1, 0, 32'h0, 0, 0);
    drive_m1(1, 0, 32'h20, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp1 = RR_BUILD ? ((i % 2) == 1) : (i == 8);
      check_eq($sformatf("t2_m1_gnt_%0d", i), m1_gnt, exp1);
      check_eq($sformatf("t2_m0_gnt_%0d", i), m0_gnt, !exp1);
      tick();
    end
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    repeat (3) tick();

    // m1 locked load then unlocking store while m0 keeps requesting.
    drive_m1(1, 0, 32'h20, 0, 1);
    #1;
    check_eq("t3_m1_gnt_a", m1_gnt, 1);
    tick();
    drive_m1(1, 1, 32'h24, 32'hCAFEF00D, 0);
    drive_m0(1, 0, 32'h10, 0, 0);
    #1;
    check_eq("t3_m1_gnt_b", m1_gnt, 1);
    check_eq("t3_m0_gnt_b", m0_gnt, 0);
    check_eq("t3_mem_r_en", mem_r_en, 1);
    check_eq("t3_mem_addr_ld", mem_addr, 32'h20);
    tick();
    drive_m1(0, 0, 0, 0, 0);
    #1;
    check_eq("t3_m0_gnt_c", m0_gnt, 1);
    check_eq("t3_mem_w_en", mem_w_en, 1);
    check_eq("t3_mem_addr_st", mem_addr, 32'h24);
    check_eq("t3_mem_data_w", mem_data_w, 32'hCAFEF00D);
    check_eq("t3_m1_rvalid", m1_rvalid, 1);
    check_eq("t3_m1_rdata", m1_rdata, 32'hA5A50001);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    #1;
    check_eq("t3_m1_rvalid_store", m1_rvalid, 0);
    check_eq("t3_mem_addr_m0", mem_addr, 32'h10);
    tick();
    #1;
    check_eq("t3_m0_rvalid", m0_rvalid, 1);
    check_eq("t3_m0_rdata", m0_rdata, 32'h12345678);
    check_eq("t3_store_landed", mem[9], 32'hCAFEF00D);
    tick();

    // m0 lock holds the port against m1 even while m0 is idle.
    drive_m0(1, 0, 32'h10, 0, 1);
    drive_m1(1, 0, 32'h20, 0, 0);
    #1;
    check_eq("t4_m0_gnt_lock", m0_gnt, 1);
    check_eq("t4_m1_gnt_lock", m1_gnt, 0);
    tick();
    m0_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("t4_m1_held_%0d", i), m1_gnt, 0);
      tick();
    end
    drive_m0(1, 0, 32'h10, 0, 0);
    #1;
    check_eq("t4_m0_unlock", m0_gnt, 1);
    check_eq("t4_m1_unlock", m1_gnt, 0);
    tick();
    #1;
    check_eq("t4_m1_after_lock", m1_gnt, RR_BUILD ? 1 : 0);
    tick();
    m0_req = 1'b0;
    #1;
    check_eq("t4_m1_alone", m1_gnt, 1);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    drive_m1(0, 0, 0, 0, 0);
    repeat (3) tick();

    // m1 access to the watchdog window is blocked; m0 passes through.
    drive_m1(1, 0, 32'h40000000, 0, 0);
    #1;
    check_eq("t5_m1_gnt", m1_gnt, 1);
    tick();
    drive_m1(0, 0, 0, 0, 0);
    #1;
    check_eq("t5_blk_r_en", mem_r_en, 0);
    check_eq("t5_blk_w_en", mem_w_en, 0);
    tick();
    #1;
    check_eq("t5_blk_rvalid", m1_rvalid, 1);
    check_eq("t5_blk_rdata", m1_rdata, 0);
    check_eq("t5_blk_err", m1_err, 1);
    drive_m0(1, 0, 32'h40000000, 0, 0);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    #1;
    check_eq("t5_m0_r_en", mem_r_en, 1);
    check_eq("t5_err_pulse", m1_err, 0);
    tick();
    #1;
    check_eq("t5_m0_rvalid", m0_rvalid, 1);
    check_eq("t5_m0_rdata", m0_rdata, 32'hDEADBEEF);
    drive_m1(1, 1, 32'h40000004, 32'h55, 0);
    tick();
    drive_m1(0, 0, 0, 0, 0);
    #1;
    check_eq("t5_blkst_w_en", mem_w_en, 0);
    tick();
    #1;
    check_eq("t5_blkst_err", m1_err, 1);
    check_eq("t5_blkst_rvalid", m1_rvalid, 0);
    tick();

    // Reset in the middle of a load's access cycle drops the transaction.
    drive_m0(1, 0, 32'h10, 0, 0);
    #1;
    check_eq("t6_m0_gnt", m0_gnt, 1);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    #1;
    check_eq("t6_r_en_before", mem_r_en, 1);
    #3;
    rst = 1'b1;
    m0_req = 1'b1;
    #1;
    check_eq("t6_rst_r_en", mem_r_en, 0);
    check_eq("t6_rst_addr", mem_addr, 0);
    check_eq("t6_rst_gnt", m0_gnt, 0);
    tick();
    rst = 1'b0;
    m0_req = 1'b0;
    #1;
    check_eq("t6_no_rvalid_a", m0_rvalid, 0);
    tick();
    #1;
    check_eq("t6_no_rvalid_b", m0_rvalid, 0);
    drive_m0(1, 0, 32'h24, 0, 0);
    #1;
    check_eq("t6_post_gnt", m0_gnt, 1);
    tick();
    drive_m0(0, 0, 0, 0, 0);
    #1;
    check_eq("t6_post_r_en", mem_r_en, 1);
    tick();
    #1;
    check_eq("t6_post_rvalid", m0_rvalid, 1);
    check_eq("t6_post_rdata", m0_rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
